// File: rtl/fetch_unit_pkg.sv
// Shared constants for the F stage: address map, exception codes, NOP word.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
//
// Contents: PC_RESET / PC_HANDLER / IM_LO / IM_HI, the CP0 ExcCode values
// used by the pipeline, NOP, and a range/alignment helper for fetch legality.
package fetch_unit_pkg;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] PC_HANDLER = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

  // CP0 Cause.ExcCode values
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // A fetch is legal when word aligned and inside [IM_LO, IM_HI].
  function automatic logic fetch_addr_ok(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr >= IM_LO) && (addr <= IM_HI);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// F-stage bus bundle: D-stage redirect/hazard inputs, IM port, F/D outputs.
// Latency: n/a (wires only).
// Backpressure: stall from the hazard unit holds the PC; no other flow control.
//
// master: the fetch unit (drives IM address and the F bundle).
// slave : the surrounding pipeline / instruction memory.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic        stall;
  logic        req;
  logic        d_eret;
  logic [31:0] epc;
  logic        d_jump_taken;
  logic [31:0] d_jump_target;
  logic        d_is_branch_jump;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic [4:0]  f_exception_code;
  logic        f_is_delay;
  logic [31:0] f_fetch_cnt;

  modport master (
    input  stall, req, d_eret, epc, d_jump_taken, d_jump_target,
           d_is_branch_jump, i_inst_rdata,
    output i_inst_addr, f_pc, f_instr, f_exception_code, f_is_delay,
           f_fetch_cnt
  );

  modport slave (
    output stall, req, d_eret, epc, d_jump_taken, d_jump_target,
           d_is_branch_jump, i_inst_rdata,
    input  i_inst_addr, f_pc, f_instr, f_exception_code, f_is_delay,
           f_fetch_cnt
  );

endinterface

// File: rtl/fetch_addr_check.sv
// Fetch address legality check: flags AdEL for misaligned or out-of-IM PCs.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports: pc (in, 32) current fetch address; adel (out, 1) address error on load.
module fetch_addr_check
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  output logic        adel
);

  assign adel = ~fetch_addr_ok(pc);

endmodule

// File: rtl/fetch_unit.sv
// F stage of the five-stage MIPS pipeline: PC register, next-PC select, AdEL check.
// Latency: IM is combinational, so f_* is valid in the same cycle as the PC.
// Backpressure: stall holds PC and the fetch counter; req overrides stall.
//
// Ports: clk, reset (sync, active-high); bus (fetch_unit_if.master) carrying
// the redirect inputs, the IM address/data and the F/D output bundle.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] fetch_cnt;
  logic        adel;
  logic        nullify;
  logic        fetch_accept;

  fetch_addr_check u_addr_check (
    .pc   (pc),
    .adel (adel)
  );

  // eret has no delay slot: whatever F holds behind it is squashed. A
  // concurrent exception request takes precedence and is not squashed here.
  assign nullify = bus.d_eret & ~bus.req;

  // The F/D register latches a new instruction only when nothing redirects
  // or holds it; eret holds off the count even while stalled.
  assign fetch_accept = ~bus.req & ~bus.stall & ~bus.d_eret;

  always_comb begin
    pc_next = pc + 32'd4;
    if (bus.req)               pc_next = PC_HANDLER;
    else if (bus.stall)        pc_next = pc;
    else if (bus.d_eret)       pc_next = bus.epc;
    else if (bus.d_jump_taken) pc_next = bus.d_jump_target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= PC_RESET;
      fetch_cnt <= 32'd0;
    end else begin
      pc <= pc_next;
      if (fetch_accept) fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  assign bus.i_inst_addr      = pc;
  assign bus.f_pc             = pc;
  assign bus.f_instr          = (nullify || adel) ? NOP : bus.i_inst_rdata;
  assign bus.f_exception_code = (!nullify && adel) ? EXC_ADEL : EXC_NONE;
  assign bus.f_is_delay       = nullify ? 1'b0 : bus.d_is_branch_jump;
  assign bus.f_fetch_cnt      = fetch_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, branch/delay slot,
// AdEL boundaries, stall/req interaction, eret nullify, reset priority.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  // IM model: recognisable word derived from the low half of the address.
  assign bus.i_inst_rdata = {16'hC0DE, bus.i_inst_addr[15:0]};

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic idle_inputs();
    bus.stall = 1'b0; bus.req = 1'b0; bus.d_eret = 1'b0; bus.epc = 32'h0;
    bus.d_jump_taken = 1'b0; bus.d_jump_target = 32'h0; bus.d_is_branch_jump = 1'b0;
  endtask

  // Advance one clock, then settle just after the edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0; #1;
    checks++; if (bus.i_inst_addr !== 32'h3000) begin errors++; $display("FAIL rst_addr: got %h want %h", bus.i_inst_addr, 32'h3000); end
    checks++; if (bus.f_fetch_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", bus.f_fetch_cnt); end
    checks++; if (bus.f_exception_code !== 5'd0) begin errors++; $display("FAIL rst_exc: got %0d want 0", bus.f_exception_code); end
    checks++; if (bus.f_is_delay !== 1'b0) begin errors++; $display("FAIL rst_delay: got %b want 0", bus.f_is_delay); end
    checks++; if (bus.f_instr !== 32'hC0DE3000) begin errors++; $display("FAIL rst_instr: got %h want %h", bus.f_instr, 32'hC0DE3000); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h3004; exp_addr[1] = 32'h3008; exp_addr[2] = 32'h300C;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.i_inst_addr !== exp_addr[i]) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, bus.i_inst_addr, exp_addr[i]); end
    end
    checks++; if (bus.f_fetch_cnt !== 32'd3) begin errors++; $display("FAIL seq_cnt: got %0d want 3", bus.f_fetch_cnt); end
    checks++; if (bus.f_exception_code !== 5'd0) begin errors++; $display("FAIL seq_exc: got %0d want 0", bus.f_exception_code); end
    tick(); // PC 0x3010, count 4
  endtask

  task automatic test_branch();
    bus.d_is_branch_jump = 1'b1; bus.d_jump_taken = 1'b1; bus.d_jump_target = 32'h3100; #1;
    checks++; if (bus.f_is_delay !== 1'b1) begin errors++; $display("FAIL br_delay: got %b want 1", bus.f_is_delay); end
    checks++; if (bus.f_pc !== 32'h3010) begin errors++; $display("FAIL br_slot_pc: got %h want %h", bus.f_pc, 32'h3010); end
    tick(); idle_inputs(); #1;
    checks++; if (bus.f_pc !== 32'h3100) begin errors++; $display("FAIL br_target_pc: got %h want %h", bus.f_pc, 32'h3100); end
    checks++; if (bus.f_is_delay !== 1'b0) begin errors++; $display("FAIL br_target_delay: got %b want 0", bus.f_is_delay); end
    checks++; if (bus.f_fetch_cnt !== 32'd5) begin errors++; $display("FAIL br_cnt: got %0d want 5", bus.f_fetch_cnt); end
  endtask

  task automatic test_adel();
    logic [31:0] tgt  [5];
    logic [4:0]  exc  [5];
    logic [31:0] ins  [5];
    tgt[0] = 32'h3102; exc[0] = 5'd4; ins[0] = 32'h0;
    tgt[1] = 32'h7000; exc[1] = 5'd4; ins[1] = 32'h0;
    tgt[2] = 32'h6FFC; exc[2] = 5'd0; ins[2] = 32'hC0DE6FFC;
    tgt[3] = 32'h2FFC; exc[3] = 5'd4; ins[3] = 32'h0;
    tgt[4] = 32'h3020; exc[4] = 5'd0; ins[4] = 32'hC0DE3020;
    for (int i = 0; i < 5; i++) begin
      bus.d_is_branch_jump = 1'b1; bus.d_jump_taken = 1'b1; bus.d_jump_target = tgt[i];
      tick(); idle_inputs(); #1;
      checks++; if (bus.f_pc !== tgt[i]) begin errors++; $display("FAIL adel_pc%0d: got %h want %h", i, bus.f_pc, tgt[i]); end
      checks++; if (bus.f_exception_code !== exc[i]) begin errors++; $display("FAIL adel_exc%0d: got %0d want %0d", i, bus.f_exception_code, exc[i]); end
      checks++; if (bus.f_instr !== ins[i]) begin errors++; $display("FAIL adel_instr%0d: got %h want %h", i, bus.f_instr, ins[i]); end
    end
    // Faulting fetches still count: 5 + 5 redirects.
    checks++; if (bus.f_fetch_cnt !== 32'd10) begin errors++; $display("FAIL adel_cnt: got %0d want 10", bus.f_fetch_cnt); end
  endtask

  task automatic test_stall_req();
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.f_pc !== 32'h3020) begin errors++; $display("FAIL stall_pc%0d: got %h want %h", i, bus.f_pc, 32'h3020); end
      checks++; if (bus.f_fetch_cnt !== 32'd10) begin errors++; $display("FAIL stall_cnt%0d: got %0d want 10", i, bus.f_fetch_cnt); end
    end
    bus.req = 1'b1; bus.d_jump_taken = 1'b1; bus.d_jump_target = 32'h3100;
    tick(); idle_inputs(); #1;
    checks++; if (bus.f_pc !== 32'h4180) begin errors++; $display("FAIL req_pc: got %h want %h", bus.f_pc, 32'h4180); end
    checks++; if (bus.f_fetch_cnt !== 32'd10) begin errors++; $display("FAIL req_cnt: got %0d want 10", bus.f_fetch_cnt); end
    bus.d_jump_taken = 1'b1; bus.d_jump_target = 32'h4200;
    tick(); idle_inputs(); #1; // PC 0x4200, count 11
  endtask

  task automatic test_eret();
    bus.d_eret = 1'b1; bus.epc = 32'h3040; bus.d_is_branch_jump = 1'b1; #1;
    checks++; if (bus.f_instr !== 32'h0) begin errors++; $display("FAIL eret_instr: got %h want 0", bus.f_instr); end
    checks++; if (bus.f_exception_code !== 5'd0) begin errors++; $display("FAIL eret_exc: got %0d want 0", bus.f_exception_code); end
    checks++; if (bus.f_is_delay !== 1'b0) begin errors++; $display("FAIL eret_delay: got %b want 0", bus.f_is_delay); end
    checks++; if (bus.f_pc !== 32'h4200) begin errors++; $display("FAIL eret_pc_hold: got %h want %h", bus.f_pc, 32'h4200); end
    tick(); idle_inputs(); #1;
    checks++; if (bus.f_pc !== 32'h3040) begin errors++; $display("FAIL eret_epc: got %h want %h", bus.f_pc, 32'h3040); end
    checks++; if (bus.f_fetch_cnt !== 32'd11) begin errors++; $display("FAIL eret_cnt: got %0d want 11", bus.f_fetch_cnt); end
    // stall + eret: PC holds, redirect lands once the stall drops.
    bus.d_eret = 1'b1; bus.epc = 32'h3080; bus.stall = 1'b1;
    tick();
    checks++; if (bus.f_pc !== 32'h3040) begin errors++; $display("FAIL eret_stall_pc: got %h want %h", bus.f_pc, 32'h3040); end
    bus.stall = 1'b0;
    tick(); idle_inputs(); #1;
    checks++; if (bus.f_pc !== 32'h3080) begin errors++; $display("FAIL eret_release_pc: got %h want %h", bus.f_pc, 32'h3080); end
    checks++; if (bus.f_fetch_cnt !== 32'd11) begin errors++; $display("FAIL eret_release_cnt: got %0d want 11", bus.f_fetch_cnt); end
    // req alongside eret: not nullified, req redirect wins.
    bus.d_eret = 1'b1; bus.epc = 32'h3300; bus.req = 1'b1; #1;
    checks++; if (bus.f_instr !== 32'hC0DE3080) begin errors++; $display("FAIL req_eret_instr: got %h want %h", bus.f_instr, 32'hC0DE3080); end
    tick(); idle_inputs(); #1;
    checks++; if (bus.f_pc !== 32'h4180) begin errors++; $display("FAIL req_eret_pc: got %h want %h", bus.f_pc, 32'h4180); end
  endtask

  task automatic test_reset_priority();
    tick(); // PC 0x4184, count 12
    checks++; if (bus.f_fetch_cnt !== 32'd12) begin errors++; $display("FAIL pre_rst_cnt: got %0d want 12", bus.f_fetch_cnt); end
    reset = 1'b1; bus.req = 1'b1; bus.d_jump_taken = 1'b1; bus.d_jump_target = 32'h3100; bus.stall = 1'b1;
    tick(); reset = 1'b0; idle_inputs(); #1;
    checks++; if (bus.f_pc !== 32'h3000) begin errors++; $display("FAIL rst_prio_pc: got %h want %h", bus.f_pc, 32'h3000); end
    checks++; if (bus.f_fetch_cnt !== 32'd0) begin errors++; $display("FAIL rst_prio_cnt: got %0d want 0", bus.f_fetch_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_adel();
    test_stall_req();
    test_eret();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
